// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port: single outstanding request/response.
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time,
// applies prioritized redirects, drops stale responses and holds the fetched
// instruction until decode takes it.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         exc_valid,
  input  logic         eret_valid,
  input  logic [31:0]  epc,
  input  logic         is_branch_taken,
  input  logic [31:0]  branch_address,
  fetch_ctrl_if.master imem,
  output logic         if_valid,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_inst,
  output logic [31:0]  pc_address
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic            redirect;
  logic [XLEN-1:0] target;

  // Redirect request and its prioritized target.
  always_comb begin
    redirect = exc_valid | eret_valid | is_branch_taken;
    if (exc_valid)       target = EXC_VECTOR;
    else if (eret_valid) target = epc;
    else                 target = branch_address;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    case (state_q)
      S_REQ: begin
        if (redirect) pc_d = target;
        if (imem.imem_ack) begin
          state_d = S_WAIT;
          if (redirect) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect) pc_d = target;
          end else begin
            if_inst_d  = imem.imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = S_REQ;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          pc_d       = pc_q + XLEN'(4);
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Request is held low asynchronously during reset.
  assign imem.imem_req  = rst & (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign pc_address     = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed plan with literal checks, then randomized
// traffic against a transaction-level model of the fetch unit.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, exc_valid, eret_valid, is_branch_taken;
  logic [31:0] epc, branch_address;
  logic        if_valid;
  logic [31:0] if_pc, if_inst, pc_address;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
    .is_branch_taken(is_branch_taken), .branch_address(branch_address),
    .imem(imem_bus.master),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .pc_address(pc_address)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Staged stimulus, applied at the next falling edge.
  logic        s_rst, s_stall, s_exc, s_eret, s_br, s_ack, s_rvalid;
  logic [31:0] s_epc, s_baddr, s_rdata;

  // Model: fetch PC, an accepted-but-unanswered request (and whether its
  // answer is already unwanted), and an instruction parked for decode.
  logic [31:0] m_pc;
  logic        m_outstanding, m_unwanted, m_parked;
  logic [31:0] m_if_pc, m_if_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    s_rst = 1'b1; s_stall = 1'b0; s_exc = 1'b0; s_eret = 1'b0; s_br = 1'b0;
    s_ack = 1'b0; s_rvalid = 1'b0; s_epc = '0; s_baddr = '0; s_rdata = '0;
  endtask

  function automatic logic model_req();
    return s_rst && !m_outstanding && !m_parked;
  endfunction

  // Apply staged inputs, check every output against the model, advance model.
  task automatic tick();
    logic        redir;
    logic [31:0] tgt;
    @(negedge clk);
    rst = s_rst; stall = s_stall; exc_valid = s_exc; eret_valid = s_eret;
    is_branch_taken = s_br; epc = s_epc; branch_address = s_baddr;
    imem_bus.imem_ack = s_ack; imem_bus.imem_rvalid = s_rvalid;
    imem_bus.imem_rdata = s_rdata;
    if (!s_rst) begin
      m_pc = RESET_PC; m_outstanding = 1'b0; m_unwanted = 1'b0;
      m_parked = 1'b0; m_if_pc = '0; m_if_inst = '0;
    end
    #1;
    chk("imem_req",   32'(imem_bus.imem_req), 32'(model_req()));
    chk("imem_addr",  imem_bus.imem_addr, m_pc);
    chk("pc_address", pc_address, m_pc);
    chk("if_valid",   32'(if_valid), 32'(m_parked));
    chk("if_pc",      if_pc, m_if_pc);
    chk("if_inst",    if_inst, m_if_inst);
    if (!s_rst) return;
    redir = s_exc | s_eret | s_br;
    tgt   = s_exc ? EXC_VECTOR : (s_eret ? s_epc : s_baddr);
    if (m_parked) begin
      if (redir)         begin m_parked = 1'b0; m_pc = tgt; end
      else if (!s_stall) begin m_parked = 1'b0; m_pc = m_pc + 32'd4; end
    end else if (m_outstanding) begin
      if (s_rvalid) begin
        m_outstanding = 1'b0;
        if (m_unwanted || redir) begin
          m_unwanted = 1'b0;
          if (redir) m_pc = tgt;
        end else begin
          m_parked = 1'b1; m_if_pc = m_pc; m_if_inst = s_rdata;
        end
      end else if (redir) begin
        m_pc = tgt; m_unwanted = 1'b1;
      end
    end else begin
      if (redir) m_pc = tgt;
      if (s_ack) begin
        m_outstanding = 1'b1;
        if (redir) m_unwanted = 1'b1;
      end
    end
  endtask

  logic       mem_busy;
  int         mem_dly;
  logic       delivering;

  initial begin
    m_pc = RESET_PC; m_outstanding = 1'b0; m_unwanted = 1'b0;
    m_parked = 1'b0; m_if_pc = '0; m_if_inst = '0;
    rst = 1'b0; stall = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
    is_branch_taken = 1'b0; epc = '0; branch_address = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;

    // Reset values.
    idle(); s_rst = 1'b0; tick();
    chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_pc", pc_address, RESET_PC);

    // First fetch and transfer.
    idle(); s_ack = 1'b1; tick();
    chk("first_addr", imem_bus.imem_addr, 32'h0);
    chk("first_req", 32'(imem_bus.imem_req), 32'd1);
    idle(); s_rvalid = 1'b1; s_rdata = 32'h2408_0001; tick();
    chk("wait_no_req", 32'(imem_bus.imem_req), 32'd0);
    idle(); tick();
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_if_pc", if_pc, 32'h0);
    chk("first_if_inst", if_inst, 32'h2408_0001);
    idle(); s_ack = 1'b1; tick();
    chk("second_addr", imem_bus.imem_addr, 32'h4);

    // Stall held four cycles with if_pc=8.
    idle(); s_rvalid = 1'b1; s_rdata = 32'h1111_1111; tick();
    idle(); tick();
    idle(); s_ack = 1'b1; tick();
    idle(); s_rvalid = 1'b1; s_rdata = 32'h2222_2222; tick();
    for (int i = 0; i < 4; i++) begin
      idle(); s_stall = 1'b1; tick();
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_if_pc", if_pc, 32'h8);
      chk("stall_if_inst", if_inst, 32'h2222_2222);
      chk("stall_no_req", 32'(imem_bus.imem_req), 32'd0);
    end
    idle(); tick();
    idle(); tick();
    chk("after_stall_addr", imem_bus.imem_addr, 32'hC);
    chk("after_stall_valid", 32'(if_valid), 32'd0);

    // Branch during WAIT drops the response.
    idle(); s_ack = 1'b1; tick();
    idle(); s_br = 1'b1; s_baddr = 32'h100; tick();
    idle(); s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; tick();
    idle(); tick();
    chk("drop_valid", 32'(if_valid), 32'd0);
    chk("branch_addr", imem_bus.imem_addr, 32'h100);

    // All three redirects in HOLD: exception wins, held instruction killed.
    idle(); s_ack = 1'b1; tick();
    idle(); s_rvalid = 1'b1; s_rdata = 32'h3333_3333; tick();
    idle(); s_exc = 1'b1; s_eret = 1'b1; s_epc = 32'h40; s_br = 1'b1; s_baddr = 32'h100; tick();
    chk("pre_kill_valid", 32'(if_valid), 32'd1);
    idle(); tick();
    chk("kill_valid", 32'(if_valid), 32'd0);
    chk("exc_addr", imem_bus.imem_addr, 32'h380);

    // ERET beats branch; redirect in REQ without ack.
    idle(); s_eret = 1'b1; s_epc = 32'h40; s_br = 1'b1; s_baddr = 32'h200; tick();
    idle(); s_br = 1'b1; s_baddr = 32'hFFFF_FFFC; tick();
    chk("eret_addr", imem_bus.imem_addr, 32'h40);

    // PC wrap.
    idle(); s_ack = 1'b1; tick();
    chk("top_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    idle(); s_rvalid = 1'b1; s_rdata = 32'h4444_4444; tick();
    idle(); tick();
    chk("top_if_pc", if_pc, 32'hFFFF_FFFC);
    idle(); s_ack = 1'b1; tick();
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);

    // Reset mid-WAIT, then a stale response in REQ.
    idle(); s_rst = 1'b0; tick();
    chk("mid_rst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_if_inst", if_inst, 32'd0);
    idle(); s_rvalid = 1'b1; s_rdata = 32'h5555_5555; tick();
    chk("stale_addr", imem_bus.imem_addr, RESET_PC);
    idle(); tick();
    chk("stale_valid", 32'(if_valid), 32'd0);
    chk("stale_req", 32'(imem_bus.imem_req), 32'd1);

    // Randomized traffic with a memory responder of variable latency.
    mem_busy = 1'b0; mem_dly = 0;
    for (int c = 0; c < 4000; c++) begin
      idle();
      s_rst   = ($urandom_range(0, 99) != 0);
      s_stall = $urandom_range(0, 1) == 1;
      s_exc   = $urandom_range(0, 19) == 0;
      s_eret  = $urandom_range(0, 14) == 0;
      s_br    = $urandom_range(0, 9) == 0;
      s_epc   = $urandom() & 32'hFFFF_FFFC;
      s_baddr = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) s_baddr = 32'hFFFF_FFFC;
      delivering = 1'b0;
      if (mem_busy) begin
        if (mem_dly == 0) begin
          s_rvalid = 1'b1; s_rdata = $urandom(); delivering = 1'b1;
        end else begin
          mem_dly--;
        end
      end else if (!m_outstanding && $urandom_range(0, 7) == 0) begin
        s_rvalid = 1'b1; s_rdata = $urandom();
      end
      if (!mem_busy) s_ack = $urandom_range(0, 2) != 0;
      if (delivering) mem_busy = 1'b0;
      if (s_ack && model_req()) begin
        mem_busy = 1'b1; mem_dly = $urandom_range(0, 3);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the fetch PC and drives a single-outstanding request/response instruction-memory port.
- Applies redirects with fixed priority: exception, then ERET, then branch.
- Discards stale responses and holds the fetched instruction until the decode stage accepts it.
- Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- EXC_VECTOR, 32'h0000_0380: redirect target on exception.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  decode not ready; transfer occurs when if_valid=1 and stall=0.
- exc_valid  in  1  exception redirect request.
- eret_valid  in  1  return-from-exception redirect request.
- epc  in  32  ERET target.
- is_branch_taken  in  1  branch redirect request.
- branch_address  in  32  branch target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  address accepted; meaningful only while imem_req=1.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction.
- pc_address  out  32  current fetch PC register.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=REQ; drop=0.
  - if_valid=0, if_pc=0, if_inst=0.
  - imem_req is forced to 0 while rst=0.
- Redirect target (combinational):
  - redirect = exc_valid | eret_valid | is_branch_taken.
  - target priority: EXC_VECTOR, then epc, then branch_address.
- Register and address rules:
  - imem_addr = pc.
  - pc_address = pc.
  - Sequential increment is pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- State REQ:
  - Outputs: imem_req=1, if_valid=0.
  - ack=0, no redirect: stay in REQ.
  - ack=0, redirect: pc<=target, stay in REQ. The request address may change before ack.
  - ack=1, no redirect: go to WAIT.
  - ack=1 with redirect in the same cycle: pc<=target, drop<=1, go to WAIT.
- State WAIT:
  - Output: imem_req=0.
  - rvalid=0 with redirect: pc<=target, drop<=1.
  - rvalid=1 with drop=1 or redirect: discard data, drop<=0, pc<=target if redirect, go to REQ.
  - rvalid=1 otherwise: if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, go to HOLD.
  - Load-to-use latency: if_valid rises the cycle after rvalid.
- State HOLD:
  - Outputs: if_valid=1; if_pc and if_inst are stable.
  - redirect (any stall value): if_valid<=0, pc<=target, go to REQ. The held instruction is killed and no transfer occurs.
  - No redirect, stall=0: transfer; if_valid<=0, pc<=pc+4, go to REQ.
  - No redirect, stall=1: hold all outputs.
- Ignored inputs: imem_rvalid in REQ or HOLD; imem_ack outside REQ.
- Rvalid from a request issued before a reset arrives in REQ and is ignored.
- Steady-state throughput with 1-cycle ack and 1-cycle rvalid: one instruction per 3 cycles.
- Simultaneous requests: exc_valid+eret_valid+is_branch_taken selects EXC_VECTOR; eret+branch selects epc.

Test Plan:
- Release reset, ack in the first REQ cycle, rvalid with rdata=32'h2408_0001 next cycle, stall=0.
  -> imem_addr=0, then if_valid=1 with if_pc=0 and if_inst=32'h2408_0001.
  -> Next request at imem_addr=4.
- Hold stall=1 for 4 cycles in HOLD with if_pc=8.
  -> if_valid, if_pc and if_inst stay stable; no imem_req.
  -> Stall release gives one transfer, then imem_addr=12.
- Branch to 32'h0000_0100 asserted during WAIT.
  -> The returning rdata is dropped (if_valid stays 0).
  -> Next imem_addr=32'h100.
- exc_valid, eret_valid (epc=32'h40) and is_branch_taken all asserted in HOLD with stall=0.
  -> Held instruction killed.
  -> imem_addr=32'h380.
- pc=32'hFFFF_FFFC fetched and transferred.
  -> Next imem_addr=32'h0000_0000.
- rst asserted mid-WAIT, deasserted, then stale rvalid arrives in REQ.
  -> Outputs are at reset values during rst.
  -> Stale data is ignored; imem_addr=RESET_PC.
